uart_rx_fifo: RTL and testbench

- Parametrised successor UART receive channel for the APB peripheral subsystem.
- Frame format is configurable: data width, parity enable/odd, oversampling ratio.
- Received characters are buffered in an internal FIFO, with per-character parity and framing status and a sticky overrun flag.
- Drains to the APB register block through a valid/ready pop port.

---
 rtl/uart_rx_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receive channel with a show-ahead receive FIFO for the APB peripheral
//   subsystem. A 2-flop synchroniser feeds a five-state receiver that samples
//   each bit at mid-period. Finished frames are pushed as {ferr, perr, data}.
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous, active-high reset
//   rxd       serial input, idle high, asynchronous to clk
//   rx_ready  consumer accepts the head entry (pop when rx_valid && rx_ready)
//   clr_ovr   single-cycle pulse, clears the overrun flag
//   rx_valid  FIFO not empty
//   rx_data   head entry data (zero while empty)
//   rx_perr   head entry parity error
//   rx_ferr   head entry framing error
//   overrun   sticky: a frame was dropped because the FIFO was full
//   level     current FIFO occupancy
//   busy      receiver not idle
module uart_rx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rx_ready,
  input  logic                          clr_ovr,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic                 ferr;
    logic                 perr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  // Synchroniser flops reset to the idle line level so release of reset
  // cannot look like a start bit.
  logic sync1, sync2, rxs;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update together from pre-edge values, regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  assign rxs = sync2;

  // Receiver
  state_t               state, state_n;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;
  logic                 cnt_clr, shift_en, par_en, push_req;
  logic                 half_pt, full_pt;

  assign half_pt = (cnt == CW'(CLKS_PER_BIT/2 - 1));
  assign full_pt = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a value held (no latch).
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    push_req = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        // Half-bit check rejects line glitches shorter than half a bit.
        if (half_pt) begin
          cnt_clr = 1'b1;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_pt) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == BW'(DATA_BITS - 1))
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (full_pt) begin
          cnt_clr = 1'b1;
          par_en  = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        // Push at mid stop bit; the idle half-bit that follows is where a
        // back-to-back start bit may begin.
        if (full_pt) begin
          cnt_clr  = 1'b1;
          push_req = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      perr_q  <= 1'b0;
    end else begin
      cnt <= (cnt_clr || state == IDLE) ? '0 : cnt + CW'(1);
      if (state == START) begin
        bit_idx <= '0;
        perr_q  <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end
      if (par_en)
        perr_q <= (((^shreg) ^ rxs) != (PARITY_ODD != 0));
    end
  end

  assign busy = (state != IDLE);

  // FIFO
  entry_t        mem [FIFO_DEPTH];
  entry_t        wr_entry, head;
  logic [AW-1:0] wptr, rptr;
  logic          full, pop, push, ovr_set;

  assign full     = (level == LW'(FIFO_DEPTH));
  assign rx_valid = (level != '0);
  assign pop      = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;
  assign wr_entry = '{ferr: ~rxs, perr: perr_q, data: shreg};

  // NOTE: the storage array has no reset; the head is masked by rx_valid so
  // stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // Set has priority over a coincident clear.
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  assign head    = mem[rptr];
  assign rx_data = rx_valid ? head.data : '0;
  assign rx_perr = rx_valid & head.perr;
  assign rx_ferr = rx_valid & head.ferr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: three instances (defaults, odd parity, and a
// 5-bit/no-parity/8-clk-per-bit variant) driven by serial frames generated
// from the frame rules, with a queue-based reference of expected entries.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a: defaults
  logic       rxd_a = 1'b1, rdy_a = 1'b0, clr_a = 1'b0;
  logic       v_a, pe_a, fe_a, ov_a, bz_a;
  logic [7:0] d_a;
  logic [2:0] lv_a;
  // Instance o: odd parity
  logic       rxd_o = 1'b1, rdy_o = 1'b0, clr_o = 1'b0;
  logic       v_o, pe_o, fe_o, ov_o, bz_o;
  logic [7:0] d_o;
  logic [2:0] lv_o;
  // Instance n: 5 data bits, no parity, 8 clk per bit
  logic       rxd_n = 1'b1, rdy_n = 1'b0, clr_n = 1'b0;
  logic       v_n, pe_n, fe_n, ov_n, bz_n;
  logic [4:0] d_n;
  logic [2:0] lv_n;

  uart_rx_fifo dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rx_ready(rdy_a), .clr_ovr(clr_a),
    .rx_valid(v_a), .rx_data(d_a), .rx_perr(pe_a), .rx_ferr(fe_a),
    .overrun(ov_a), .level(lv_a), .busy(bz_a)
  );

  uart_rx_fifo #(.PARITY_ODD(1)) dut_o (
    .clk(clk), .rst(rst), .rxd(rxd_o), .rx_ready(rdy_o), .clr_ovr(clr_o),
    .rx_valid(v_o), .rx_data(d_o), .rx_perr(pe_o), .rx_ferr(fe_o),
    .overrun(ov_o), .level(lv_o), .busy(bz_o)
  );

  uart_rx_fifo #(.DATA_BITS(5), .PARITY_EN(0), .CLKS_PER_BIT(8)) dut_n (
    .clk(clk), .rst(rst), .rxd(rxd_n), .rx_ready(rdy_n), .clr_ovr(clr_n),
    .rx_valid(v_n), .rx_data(d_n), .rx_perr(pe_n), .rx_ferr(fe_n),
    .overrun(ov_n), .level(lv_n), .busy(bz_n)
  );

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0:       rxd_a = v;
      1:       rxd_o = v;
      default: rxd_n = v;
    endcase
  endtask

  task automatic set_rdy(input int w, input logic v);
    case (w)
      0:       rdy_a = v;
      1:       rdy_o = v;
      default: rdy_n = v;
    endcase
  endtask

  task automatic head(input int w, output logic v, output logic [7:0] d,
                      output logic pe, output logic fe, output logic ov,
                      output logic bz, output logic [2:0] lv);
    case (w)
      0: begin v = v_a; d = d_a; pe = pe_a; fe = fe_a; ov = ov_a; bz = bz_a; lv = lv_a; end
      1: begin v = v_o; d = d_o; pe = pe_o; fe = fe_o; ov = ov_o; bz = bz_o; lv = lv_o; end
      default: begin
        v = v_n; d = {3'b000, d_n}; pe = pe_n; fe = fe_n; ov = ov_n; bz = bz_n; lv = lv_n;
      end
    endcase
  endtask

  // Expected parity error from a count of ones: data plus parity bit must
  // have an even (or, for odd parity, odd) number of ones.
  function automatic logic calc_perr(input logic [7:0] d, input int nb,
                                     input logic pbit, input bit odd);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    ones += int'(pbit);
    return ((ones % 2) == 1) != odd;
  endfunction

  // Drives one frame starting at the current falling edge; returns on the
  // falling edge where the next frame may start. A low stop bit is released
  // a quarter bit early so the line is idle again shortly after the sample.
  task automatic send(input int w, input logic [7:0] data, input logic pbit, input logic stop);
    int nb  = (w == 2) ? 5 : 8;
    int cpb = (w == 2) ? 8 : 16;
    set_rx(w, 1'b0);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      set_rx(w, data[i]);
      repeat (cpb) @(negedge clk);
    end
    if (w != 2) begin
      set_rx(w, pbit);
      repeat (cpb) @(negedge clk);
    end
    if (stop) begin
      set_rx(w, 1'b1);
      repeat (cpb) @(negedge clk);
    end else begin
      set_rx(w, 1'b0);
      repeat (cpb * 3 / 4) @(negedge clk);
      set_rx(w, 1'b1);
      repeat (cpb / 4) @(negedge clk);
    end
  endtask

  task automatic pop_expect(input int w, input string tag, input logic [7:0] d,
                            input logic pe, input logic fe);
    logic v, hpe, hfe, ov, bz;
    logic [7:0] hd;
    logic [2:0] lv;
    head(w, v, hd, hpe, hfe, ov, bz, lv);
    check({tag, ".valid"}, v, 1);
    check({tag, ".data"}, hd, d);
    check({tag, ".perr"}, hpe, pe);
    check({tag, ".ferr"}, hfe, fe);
    set_rdy(w, 1'b1);
    @(negedge clk);
    set_rdy(w, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic v, pe, fe, ov, bz;
    logic [7:0] d;
    logic [2:0] lv;
    int lat;
    int minlev;
    logic [7:0] fill [4];
    logic [7:0] rd;
    logic rp, rs;
    exp_t e;

    // Reset state
    repeat (3) @(negedge clk);
    head(0, v, d, pe, fe, ov, bz, lv);
    check("rst.valid", v, 0);
    check("rst.data", d, 0);
    check("rst.perr", pe, 0);
    check("rst.ferr", fe, 0);
    check("rst.overrun", ov, 0);
    check("rst.level", lv, 0);
    check("rst.busy", bz, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic frame 0xAA, latency from start edge to rx_valid
    lat = 0;
    fork
      send(0, 8'hAA, 1'b0, 1'b1);
      begin
        while (!v_a && lat < 300) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("latency_168_172", (lat >= 168 && lat <= 172), 1);
    check("aa.level", lv_a, 1);
    check("aa.busy_idle", bz_a, 0);
    pop_expect(0, "aa", 8'hAA, 1'b0, 1'b0);
    check("aa.level_after_pop", lv_a, 0);

    // Parity error, then framing error
    send(0, 8'hAA, 1'b1, 1'b1);
    pop_expect(0, "aa_perr", 8'hAA, 1'b1, 1'b0);
    send(0, 8'hAA, 1'b0, 1'b0);
    repeat (24) @(negedge clk);
    check("aa_ferr.level", lv_a, 1);
    check("aa_ferr.busy", bz_a, 0);
    pop_expect(0, "aa_ferr", 8'hAA, 1'b0, 1'b1);

    // Odd parity instance
    send(1, 8'hAA, 1'b1, 1'b1);
    pop_expect(1, "odd_aa", 8'hAA, 1'b0, 1'b0);
    rd = 8'($urandom);
    rp = 1'($urandom);
    send(1, rd, rp, 1'b1);
    pop_expect(1, "odd_rand", rd, calc_perr(rd, 8, rp, 1'b1), 1'b0);

    // Overrun: five back-to-back frames into a 4-entry FIFO
    for (int i = 1; i <= 5; i++) send(0, 8'(i), ^(8'(i)), 1'b1);
    check("ovr.level", lv_a, 4);
    check("ovr.flag", ov_a, 1);
    for (int i = 1; i <= 4; i++) pop_expect(0, "ovr_pop", 8'(i), 1'b0, 1'b0);
    check("ovr.level_empty", lv_a, 0);
    check("ovr.sticky", ov_a, 1);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    check("empty_pop.level", lv_a, 0);
    check("empty_pop.valid", v_a, 0);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("clr_ovr", ov_a, 0);

    // Full FIFO with a pop on the exact push cycle of a 5th frame
    for (int i = 0; i < 4; i++) begin
      fill[i] = 8'($urandom);
      send(0, fill[i], ^fill[i], 1'b1);
    end
    check("full.level", lv_a, 4);
    rd = 8'($urandom);
    minlev = 7;
    fork
      send(0, rd, ^rd, 1'b1);
      begin
        for (int k = 1; k <= 176; k++) begin
          @(negedge clk);
          if (k == 170) rdy_a = 1'b1;
          else if (k == 171) rdy_a = 1'b0;
          if (k >= 150 && int'(lv_a) < minlev) minlev = int'(lv_a);
        end
      end
    join
    check("fullpop.min_level", minlev, 4);
    check("fullpop.level", lv_a, 4);
    check("fullpop.no_overrun", ov_a, 0);
    for (int i = 1; i < 4; i++) pop_expect(0, "fullpop_pop", fill[i], 1'b0, 1'b0);
    pop_expect(0, "fullpop_tail", rd, 1'b0, 1'b0);

    // Glitch shorter than half a bit
    rxd_a = 1'b0;
    repeat (4) @(negedge clk);
    rxd_a = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch.busy_start", bz_a, 1);
    repeat (20) @(negedge clk);
    check("glitch.busy_end", bz_a, 0);
    check("glitch.level", lv_a, 0);

    // Reset in the middle of DATA with one entry buffered
    send(0, 8'h5A, ^(8'h5A), 1'b1);
    check("pre_rst.valid", v_a, 1);
    rxd_a = 1'b0;
    repeat (16) @(negedge clk);
    rxd_a = 1'b1;
    repeat (16) @(negedge clk);
    rxd_a = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_data.busy", bz_a, 1);
    rst = 1'b1;
    #1;
    head(0, v, d, pe, fe, ov, bz, lv);
    check("midrst.valid", v, 0);
    check("midrst.data", d, 0);
    check("midrst.perr", pe, 0);
    check("midrst.ferr", fe, 0);
    check("midrst.overrun", ov, 0);
    check("midrst.level", lv, 0);
    check("midrst.busy", bz, 0);
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst.level", lv_a, 0);
    rd = 8'($urandom);
    send(0, rd, ^rd, 1'b1);
    check("post_rst.level_one", lv_a, 1);
    pop_expect(0, "post_rst", rd, 1'b0, 1'b0);

    // Randomized frames against the queue model
    for (int round = 0; round < 2; round++) begin
      for (int f = 0; f < 3; f++) begin
        rd = 8'($urandom);
        rp = 1'($urandom);
        rs = 1'($urandom);
        send(0, rd, rp, rs);
        repeat (24) @(negedge clk);
        if (q.size() < 4) begin
          e.d  = rd;
          e.pe = calc_perr(rd, 8, rp, 1'b0);
          e.fe = !rs;
          q.push_back(e);
        end
      end
      check("rand.level", lv_a, q.size());
      while (q.size() > 0) begin
        e = q.pop_front();
        pop_expect(0, "rand_pop", e.d, e.pe, e.fe);
      end
    end

    // Narrow instance: 5 data bits, no parity
    send(2, 8'h0D, 1'b0, 1'b1);
    pop_expect(2, "narrow_0d", 8'h0D, 1'b0, 1'b0);
    rd = {3'b000, 5'($urandom)};
    send(2, rd, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    check("narrow_ferr.level", lv_n, 1);
    pop_expect(2, "narrow_ferr", rd, 1'b0, 1'b1);
    check("narrow.level_end", lv_n, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
